// File: rtl/seq_gen_pkg.sv
// Shared types and default widths for the serial pattern generator.
package seq_gen_pkg;

  localparam int unsigned DefPatW = 8;
  localparam int unsigned DefLenW = 4;
  localparam int unsigned DefCntW = 4;
  localparam int unsigned DefGapW = 4;

  typedef enum logic [1:0] {
    StIdle,
    StShift,
    StGap,
    StDone
  } state_e;

endpackage

// File: rtl/seq_load_cnt.sv
// Loadable down-counter with enable and zero flag; load has priority over enable.
module seq_load_cnt
  import seq_gen_pkg::*;
#(
  parameter int unsigned W = 4
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         load_i,
  input  logic         en_i,
  input  logic [W-1:0] load_val_i,
  output logic [W-1:0] cnt_o,
  output logic [W-1:0] nxt_o,
  output logic         zero_o
);

  logic [W-1:0] cnt_q, cnt_d;

  // Next count: load, decrement, or hold.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (en_i) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  // Count register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o  = cnt_q;
  assign nxt_o  = cnt_d;
  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/seq_pattern_tx.sv
// Serial pattern generator: shifts a latched pattern out MSB-first, with repeats and idle gaps.
module seq_pattern_tx
  import seq_gen_pkg::*;
#(
  parameter int unsigned PAT_W = DefPatW,
  parameter int unsigned LEN_W = DefLenW,
  parameter int unsigned CNT_W = DefCntW,
  parameter int unsigned GAP_W = DefGapW
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic             hold,
  input  logic [PAT_W-1:0] pattern,
  input  logic [LEN_W-1:0] pat_len,
  input  logic [CNT_W-1:0] repeat_n,
  input  logic [GAP_W-1:0] gap,
  output logic             bit_out,
  output logic             bit_valid,
  output logic             busy,
  output logic             done
);

  localparam int unsigned IdxW = (PAT_W > 1) ? $clog2(PAT_W) : 1;

  state_e state_q, state_d;

  logic [PAT_W-1:0] pat_q, pat_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [GAP_W-1:0] gap_q, gap_d;

  logic bit_out_q, bit_out_d;
  logic bit_valid_q, bit_valid_d;
  logic busy_q, busy_d;
  logic done_q, done_d;

  logic [LEN_W-1:0] eff_len;
  logic [CNT_W-1:0] eff_rep_m1;

  logic            idx_ld, idx_en, idx_zero;
  logic [IdxW-1:0] idx_val, idx_cnt, idx_nxt;
  logic            rep_ld, rep_en, rep_zero;
  logic [CNT_W-1:0] rep_cnt, rep_nxt;
  logic             gap_ld, gap_en, gap_zero;
  logic [GAP_W-1:0] gap_val, gap_cnt, gap_nxt;

  // Clamp request length to the pattern width; a repeat count of 0 means one pass.
  always_comb begin
    eff_len    = (pat_len > LEN_W'(PAT_W)) ? LEN_W'(PAT_W) : pat_len;
    eff_rep_m1 = (repeat_n == '0) ? '0 : repeat_n - CNT_W'(1);
    // Index reload comes from the live request in IDLE, else from the latched length.
    idx_val    = IdxW'(((state_q == StIdle) ? eff_len : len_q) - LEN_W'(1));
    // Gap counter runs gap-1 .. 0 so the zero flag marks the last idle cycle.
    gap_val    = gap_q - GAP_W'(1);
  end

  seq_load_cnt #(
    .W(IdxW)
  ) u_idx_cnt (
    .clk_i     (clk),
    .rst_ni    (reset),
    .load_i    (idx_ld),
    .en_i      (idx_en),
    .load_val_i(idx_val),
    .cnt_o     (idx_cnt),
    .nxt_o     (idx_nxt),
    .zero_o    (idx_zero)
  );

  // Holds the number of repetitions still to send after the current one.
  seq_load_cnt #(
    .W(CNT_W)
  ) u_rep_cnt (
    .clk_i     (clk),
    .rst_ni    (reset),
    .load_i    (rep_ld),
    .en_i      (rep_en),
    .load_val_i(eff_rep_m1),
    .cnt_o     (rep_cnt),
    .nxt_o     (rep_nxt),
    .zero_o    (rep_zero)
  );

  seq_load_cnt #(
    .W(GAP_W)
  ) u_gap_cnt (
    .clk_i     (clk),
    .rst_ni    (reset),
    .load_i    (gap_ld),
    .en_i      (gap_en),
    .load_val_i(gap_val),
    .cnt_o     (gap_cnt),
    .nxt_o     (gap_nxt),
    .zero_o    (gap_zero)
  );

  logic unused_cnt;
  assign unused_cnt = ^{idx_cnt, rep_cnt, rep_nxt, gap_cnt, gap_nxt};

  // Next-state, counter control and registered-output next values.
  always_comb begin
    state_d = state_q;
    pat_d   = pat_q;
    len_d   = len_q;
    gap_d   = gap_q;
    idx_ld  = 1'b0;
    idx_en  = 1'b0;
    rep_ld  = 1'b0;
    rep_en  = 1'b0;
    gap_ld  = 1'b0;
    gap_en  = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start && !abort) begin
          pat_d  = pattern;
          len_d  = eff_len;
          gap_d  = gap;
          rep_ld = 1'b1;
          if (eff_len == '0) begin
            state_d = StDone;
          end else begin
            idx_ld  = 1'b1;
            state_d = StShift;
          end
        end
      end
      StShift: begin
        if (abort) begin
          state_d = StIdle;
        end else if (!hold) begin
          if (!idx_zero) begin
            idx_en = 1'b1;
          end else if (rep_zero) begin
            state_d = StDone;
          end else begin
            rep_en = 1'b1;
            if (gap_q != '0) begin
              gap_ld  = 1'b1;
              state_d = StGap;
            end else begin
              idx_ld = 1'b1;
            end
          end
        end
      end
      StGap: begin
        if (abort) begin
          state_d = StIdle;
        end else if (!hold) begin
          if (gap_zero) begin
            idx_ld  = 1'b1;
            state_d = StShift;
          end else begin
            gap_en = 1'b1;
          end
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    // Outputs are computed from the next state so they can be registered.
    bit_valid_d = (state_d == StShift);
    bit_out_d   = (state_d == StShift) ? pat_d[idx_nxt] : 1'b0;
    busy_d      = (state_d != StIdle);
    done_d      = (state_d == StDone);
  end

  // State, latched request and output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= StIdle;
      pat_q       <= '0;
      len_q       <= '0;
      gap_q       <= '0;
      bit_out_q   <= 1'b0;
      bit_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      pat_q       <= pat_d;
      len_q       <= len_d;
      gap_q       <= gap_d;
      bit_out_q   <= bit_out_d;
      bit_valid_q <= bit_valid_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign bit_out   = bit_out_q;
  assign bit_valid = bit_valid_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_seq_pattern_tx.sv
// Directed bench for seq_pattern_tx with a bit scoreboard fed at start time.
module tb_seq_pattern_tx;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic       hold = 1'b0;
  logic [7:0] pattern = '0;
  logic [3:0] pat_len = '0;
  logic [3:0] repeat_n = '0;
  logic [3:0] gap = '0;
  logic       bit_out, bit_valid, busy, done;

  int checks = 0;
  int errors = 0;
  bit exp_q[$];
  bit exp_bit;

  always #5 clk = ~clk;

  seq_pattern_tx dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .abort    (abort),
    .hold     (hold),
    .pattern  (pattern),
    .pat_len  (pat_len),
    .repeat_n (repeat_n),
    .gap      (gap),
    .bit_out  (bit_out),
    .bit_valid(bit_valid),
    .busy     (busy),
    .done     (done)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drive a request, queue its expected bits, and return in the first cycle after acceptance.
  task automatic start_xfer(input logic [7:0] p, input logic [3:0] l, input logic [3:0] r,
                            input logic [3:0] g);
    int len_e;
    int rep_e;
    len_e = (l > 4'd8) ? 8 : int'(l);
    rep_e = (r == 4'd0) ? 1 : int'(r);
    for (int rr = 0; rr < rep_e; rr++) begin
      for (int i = len_e - 1; i >= 0; i--) exp_q.push_back(p[i]);
    end
    pattern  = p;
    pat_len  = l;
    repeat_n = r;
    gap      = g;
    start    = 1'b1;
    step();
    start    = 1'b0;
    // Scramble inputs; the transfer must use the latched copy.
    pattern  = ~p;
    pat_len  = 4'd1;
    repeat_n = 4'd7;
    gap      = 4'd9;
  endtask

  // n0 = cycle index (relative to acceptance) at entry; exp = cycle in which done must be high.
  task automatic wait_done(input string tag, input int n0, input int exp);
    int n;
    n = n0;
    while (done !== 1'b1 && n < 200) begin
      step();
      n++;
    end
    chk({tag, " done_cycle"}, n, exp);
    step();
    chk({tag, " busy_off"}, {31'b0, busy}, 0);
    chk({tag, " done_single"}, {31'b0, done}, 0);
    chk({tag, " bits_left"}, exp_q.size(), 0);
  endtask

  // Scoreboard: a bit is consumed on each valid, non-held cycle.
  always @(negedge clk) begin
    if (reset === 1'b1 && bit_valid === 1'b1 && hold === 1'b0) begin
      checks++;
      assert (exp_q.size() > 0)
      else begin
        errors++;
        $error("FAIL extra_bit observed=%0b expected=none", bit_out);
      end
      if (exp_q.size() > 0) begin
        exp_bit = exp_q.pop_front();
        checks++;
        assert (bit_out === exp_bit)
        else begin
          errors++;
          $error("FAIL stream_bit observed=%0b expected=%0b", bit_out, exp_bit);
        end
      end
    end
  end

  initial begin
    #12;
    chk("rst bit_out", {31'b0, bit_out}, 0);
    chk("rst bit_valid", {31'b0, bit_valid}, 0);
    chk("rst busy", {31'b0, busy}, 0);
    chk("rst done", {31'b0, done}, 0);
    reset = 1'b1;
    step();

    // Single pass 1011.
    start_xfer(8'h0B, 4'd4, 4'd1, 4'd0);
    chk("t1 first_valid", {31'b0, bit_valid}, 1);
    chk("t1 first_bit", {31'b0, bit_out}, 1);
    chk("t1 busy", {31'b0, busy}, 1);
    wait_done("t1", 1, 5);

    // Two passes with a 2-cycle gap, then back-to-back.
    start_xfer(8'h0B, 4'd4, 4'd2, 4'd2);
    wait_done("t2", 1, 11);
    start_xfer(8'h0B, 4'd4, 4'd2, 4'd0);
    wait_done("t3", 1, 9);

    // Hold for 3 cycles on the second bit.
    start_xfer(8'h0B, 4'd4, 4'd1, 4'd0);
    step();
    hold = 1'b1;
    repeat (3) begin
      chk("t4 held_valid", {31'b0, bit_valid}, 1);
      chk("t4 held_bit", {31'b0, bit_out}, 0);
      step();
    end
    hold = 1'b0;
    chk("t4 last_held_bit", {31'b0, bit_out}, 0);
    wait_done("t4", 5, 8);

    // Abort in the gap, then restart one cycle later.
    start_xfer(8'h0B, 4'd4, 4'd2, 4'd2);
    repeat (4) step();
    chk("t5 gap_valid", {31'b0, bit_valid}, 0);
    chk("t5 gap_busy", {31'b0, busy}, 1);
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("t5 abort_busy", {31'b0, busy}, 0);
    chk("t5 abort_done", {31'b0, done}, 0);
    exp_q.delete();
    start_xfer(8'h0B, 4'd4, 4'd1, 4'd0);
    chk("t5 restart_bit", {31'b0, bit_out}, 1);
    wait_done("t5", 1, 5);

    // Zero length, oversize length, zero repeat count.
    start_xfer(8'hFF, 4'd0, 4'd1, 4'd0);
    chk("t6 no_valid", {31'b0, bit_valid}, 0);
    wait_done("t6", 1, 1);
    start_xfer(8'hC3, 4'd15, 4'd1, 4'd0);
    wait_done("t7", 1, 9);
    start_xfer(8'h5A, 4'd6, 4'd0, 4'd1);
    wait_done("t8", 1, 7);

    // Start while busy is ignored.
    start_xfer(8'h0B, 4'd4, 4'd1, 4'd0);
    step();
    pattern = 8'hFF;
    pat_len = 4'd8;
    start   = 1'b1;
    step();
    start   = 1'b0;
    wait_done("t9", 3, 5);

    // Start and abort together in IDLE: request dropped.
    pattern = 8'h0B;
    pat_len = 4'd4;
    start   = 1'b1;
    abort   = 1'b1;
    step();
    start   = 1'b0;
    abort   = 1'b0;
    chk("t10 dropped_busy", {31'b0, busy}, 0);
    chk("t10 dropped_valid", {31'b0, bit_valid}, 0);

    // Asynchronous reset mid-shift.
    start_xfer(8'hA5, 4'd8, 4'd1, 4'd0);
    step();
    #2 reset = 1'b0;
    #1;
    chk("t11 rst bit_out", {31'b0, bit_out}, 0);
    chk("t11 rst bit_valid", {31'b0, bit_valid}, 0);
    chk("t11 rst busy", {31'b0, busy}, 0);
    chk("t11 rst done", {31'b0, done}, 0);
    exp_q.delete();
    #2 reset = 1'b1;
    step();
    chk("t11 idle_busy", {31'b0, busy}, 0);
    chk("t11 idle_done", {31'b0, done}, 0);
    start_xfer(8'h0B, 4'd4, 4'd1, 4'd0);
    wait_done("t11", 1, 5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
